bram_rr_port_arbiter: RTL
=========================

Name: bram_rr_port_arbiter

Overview:
- Shares one `bram_r1_w1` instance (read port p0, write port p1) between NUM_REQ requesters.
- Each requester issues single-beat read or write requests over valid/ready.
- Reads and writes are arbitrated independently, each with its own round-robin pointer, so one read and one write can issue per cycle.
- Read data returns one cycle after grant, with a per-requester one-hot response strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 10, BRAM address width; matches the BRAM instance.
- ELEMENT_WIDTH, 16, data word width; matches the BRAM instance.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_wr  in  NUM_REQ  1 = write request, 0 = read request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*ELEMENT_WIDTH  write data; requester i uses slice [i*ELEMENT_WIDTH +: ELEMENT_WIDTH].
- req_ready  out  NUM_REQ  one-hot within the read class and within the write class; request accepted when valid&ready.
- rsp_valid  out  NUM_REQ  registered one-hot strobe: read data for requester i is on rsp_data.
- rsp_data  out  ELEMENT_WIDTH  read data, shared by all requesters; equals p0_rd_data.
- p0_addr_en  out  1  BRAM read-port enable.
- p0_addr_data  out  ADDR_WIDTH  BRAM read address.
- p0_rd_en  out  1  BRAM read strobe.
- p0_rd_data  in  ELEMENT_WIDTH  BRAM read data; valid one cycle after enable.
- p1_addr_en  out  1  BRAM write-port enable.
- p1_addr_data  out  ADDR_WIDTH  BRAM write address.
- p1_wr_en  out  1  BRAM write strobe.
- p1_wr_data  out  ELEMENT_WIDTH  BRAM write data.

Behaviour:
- Request classes:
  - rd_req[i] = req_valid[i] & ~req_wr[i].
  - wr_req[i] = req_valid[i] & req_wr[i].
- Round-robin grant, read and write classes independent:
  - Registered pointers rd_ptr and wr_ptr, each in 0..NUM_REQ-1, reset to 0.
  - Grant goes to the first requesting index scanning rd_ptr, rd_ptr+1, ... with wrap modulo NUM_REQ (same for wr_ptr).
- Grant is combinational in the same cycle.
  - req_ready[i] = rd_gnt[i] | wr_gnt[i].
  - A requester never holds both grants, since its request is one class only.
- Pointer update on grant to index g: pointer <= (g+1) mod NUM_REQ. With no request in a class, that pointer holds.
- Read issue (cycle N, any rd_gnt):
  - p0_addr_en = p0_rd_en = 1.
  - p0_addr_data = granted address.
  - Otherwise p0_addr_en = p0_rd_en = 0 and p0_addr_data = 0.
- Write issue (cycle N, any wr_gnt):
  - p1_addr_en = p1_wr_en = 1.
  - p1_addr_data and p1_wr_data = granted slices.
  - Otherwise all p1 outputs = 0.
- Read response:
  - rsp_valid <= rd_gnt on each clk edge, so rsp_valid is high in cycle N+1 for exactly one cycle.
  - rsp_data = p0_rd_data, combinational pass-through. Its value is only meaningful while rsp_valid != 0.
  - Requesters cannot backpressure responses.
- Throughput: one read and one write per cycle, pipelined. Back-to-back reads produce back-to-back rsp_valid.
- Same-address read and write in the same cycle: both issue. The read returns the OLD word (read-first BRAM); the new word is visible to reads granted from cycle N+1 onward.
- Fairness: with all NUM_REQ requesters continuously requesting one class, each is granted exactly once per NUM_REQ cycles in that class.
- Request rules:
  - Requester holds req_valid, req_wr, req_addr and req_wdata stable until accepted.
  - Dropping valid before acceptance is allowed; no state is kept for it.
- Reset (rst=0, asynchronous):
  - rd_ptr = wr_ptr = 0 and rsp_valid = 0 immediately.
  - Combinational outputs depend on req_valid. A bench must hold req_valid=0 during reset.
  - A read granted in the cycle before reset asserts produces no response; the in-flight read is dropped.
  - After deassertion, the first grant follows from pointer 0.
- No state machine beyond the pointers and the rsp_valid pipeline register; no FIFOs.

Test Plan:
- Single read: NUM_REQ=4; after reset, BRAM[5]=0xBEEF; req 2 reads addr 5 -> req_ready=4'b0100 in cycle N; rsp_valid=4'b0100 and rsp_data=0xBEEF in cycle N+1; rsp_valid=0 in N+2.
- Round-robin reads: all 4 requesters hold reads to addrs 0..3 (contents 0x10..0x13) -> grants in order 0,1,2,3,0; rsp_valid one-hot in the same order one cycle later with data 0x10,0x11,0x12,0x13.
- Concurrent read and write: req 0 writes 0xAAAA to addr 7 while req 1 reads addr 7 (old value 0x1234) in the same cycle -> both ready; rsp_data=0x1234; a read of addr 7 next cycle returns 0xAAAA.
- Write pointer independence: reqs 1 and 3 write, req 2 reads, for 4 cycles -> write grants alternate 1,3,1,3; req 2 gets a read grant every cycle.
- Reset mid-flight: grant a read to req 0 at cycle N and pull rst low before edge N+1 -> rsp_valid stays 0; after release, with reqs 0 and 3 requesting reads, req 0 is granted first (pointer=0).
- Idle: req_valid=0 for 10 cycles -> all p0/p1 enables 0, rsp_valid=0, pointers unchanged.

Source files
------------

// File: rtl/bram_rr_port_arbiter.sv
// bram_rr_port_arbiter
//
// Shares one read-first BRAM (read port p0, write port p1) between NUM_REQ
// requesters. Read and write requests are arbitrated independently, each
// class with its own round-robin pointer, so one read and one write can be
// issued in the same cycle. Read data comes back one cycle after the grant,
// tagged by a registered one-hot rsp_valid strobe.
//
// Ports
//   clk           clock, all logic on the rising edge
//   rst           asynchronous reset, active low
//   req_valid     per-requester request pending
//   req_wr        per-requester request type (1 = write, 0 = read)
//   req_addr      packed per-requester addresses, slice i*ADDR_WIDTH
//   req_wdata     packed per-requester write data, slice i*ELEMENT_WIDTH
//   req_ready     combinational grant, accepted when valid & ready
//   rsp_valid     one-hot read response strobe, one cycle after the grant
//   rsp_data      shared read data (pass-through of p0_rd_data)
//   p0_*          BRAM read port
//   p1_*          BRAM write port
module bram_rr_port_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ADDR_WIDTH    = 10,
  parameter int ELEMENT_WIDTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*ELEMENT_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [ELEMENT_WIDTH-1:0]         rsp_data,
  output logic                             p0_addr_en,
  output logic [ADDR_WIDTH-1:0]            p0_addr_data,
  output logic                             p0_rd_en,
  input  logic [ELEMENT_WIDTH-1:0]         p0_rd_data,
  output logic                             p1_addr_en,
  output logic [ADDR_WIDTH-1:0]            p1_addr_data,
  output logic                             p1_wr_en,
  output logic [ELEMENT_WIDTH-1:0]         p1_wr_data
);

  localparam int PTR_W = $clog2(NUM_REQ);
  // Highest legal index, widened by one bit so pointer+offset sums fit.
  localparam logic [PTR_W:0] LAST_IDX = (PTR_W+1)'(NUM_REQ - 1);

  logic [NUM_REQ-1:0]       rd_req;
  logic [NUM_REQ-1:0]       wr_req;
  logic [NUM_REQ-1:0]       rd_gnt;
  logic [NUM_REQ-1:0]       wr_gnt;
  logic [NUM_REQ-1:0]       rsp_valid_reg;
  logic [PTR_W-1:0]         rd_ptr_reg;
  logic [PTR_W-1:0]         rd_ptr_next;
  logic [PTR_W-1:0]         wr_ptr_reg;
  logic [PTR_W-1:0]         wr_ptr_next;
  logic [PTR_W-1:0]         rd_idx;
  logic [PTR_W-1:0]         wr_idx;
  logic                     rd_any;
  logic                     wr_any;
  logic [ADDR_WIDTH-1:0]    addr_arr  [NUM_REQ];
  logic [ELEMENT_WIDTH-1:0] wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*ELEMENT_WIDTH +: ELEMENT_WIDTH];
      assign rd_req[gi]    = req_valid[gi] & ~req_wr[gi];
      assign wr_req[gi]    = req_valid[gi] &  req_wr[gi];
    end
  endgenerate

  // Returns {found, index} of the first set request scanning from ptr
  // upward with wrap-around at NUM_REQ.
  function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [PTR_W-1:0]   ptr);
    logic [PTR_W:0]   pos;
    logic [PTR_W-1:0] idx;
    logic             found;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos > LAST_IDX) begin
        pos = pos - (PTR_W+1)'(NUM_REQ);
      end
      if (!found && req[pos[PTR_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[PTR_W-1:0];
      end
    end
    return {found, idx};
  endfunction

  // The pointer moves to the slot just past the winner.
  function automatic logic [PTR_W-1:0] next_slot(input logic [PTR_W-1:0] idx);
    return (idx == LAST_IDX[PTR_W-1:0]) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    {rd_any, rd_idx} = rr_pick(rd_req, rd_ptr_reg);
    {wr_any, wr_idx} = rr_pick(wr_req, wr_ptr_reg);

    rd_gnt = '0;
    wr_gnt = '0;
    if (rd_any) rd_gnt[rd_idx] = 1'b1;
    if (wr_any) wr_gnt[wr_idx] = 1'b1;
    req_ready = rd_gnt | wr_gnt;

    rd_ptr_next = rd_any ? next_slot(rd_idx) : rd_ptr_reg;
    wr_ptr_next = wr_any ? next_slot(wr_idx) : wr_ptr_reg;

    p0_addr_en   = rd_any;
    p0_rd_en     = rd_any;
    p0_addr_data = rd_any ? addr_arr[rd_idx] : '0;

    p1_addr_en   = wr_any;
    p1_wr_en     = wr_any;
    p1_addr_data = wr_any ? addr_arr[wr_idx]  : '0;
    p1_wr_data   = wr_any ? wdata_arr[wr_idx] : '0;
  end

  // Reset also clears rsp_valid_reg, so a read granted just before reset
  // never produces a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      rsp_valid_reg <= '0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      rsp_valid_reg <= rd_gnt;
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = p0_rd_data;

endmodule
